// File: rtl/layer1_relu_controller.sv
// layer1_relu_controller
// Hidden-layer stage of the network datapath. It captures one input sample and
// accumulates RELU_NODES weighted sums in parallel, one input feature per cycle.
// It then adds the bias, applies ReLU with a right shift and saturation, and
// holds the packed activations until layer 2 acknowledges them.
// The weight and bias registers can be rewritten while the stage is idle.

module layer1_relu_controller #(
    parameter int IN_NODES          = 4,
    parameter int RELU_NODES        = 4,
    parameter int IN_BIT_WIDTH      = 4,
    parameter int WEIGHTS_BIT_WIDTH = 4,
    parameter int OUT_BIT_WIDTH     = 4,
    parameter int OUT_SHIFT         = 0,
    parameter int INDEX_WIDTH       = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    inputsReady,
    input  logic [IN_NODES*IN_BIT_WIDTH-1:0]        layer1Input,
    output logic                                    inputsRecieved,
    input  logic                                    weightWriteEnable,
    input  logic                                    biasWriteEnable,
    input  logic [INDEX_WIDTH-1:0]                  WriteAddressSelect,
    input  logic [RELU_NODES*WEIGHTS_BIT_WIDTH-1:0] writeIn,
    input  logic                                    outputsRecieved,
    output logic                                    outputsReady,
    output logic [RELU_NODES*OUT_BIT_WIDTH-1:0]     layer1Output
);

    localparam int W   = WEIGHTS_BIT_WIDTH;
    localparam int ACC = IN_BIT_WIDTH + WEIGHTS_BIT_WIDTH + $clog2(IN_NODES) + 1;
    localparam logic signed [ACC-1:0] SAT_MAX = ACC'((1 << OUT_BIT_WIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT,
        S_OUTPUT
    } state_t;

    state_t                          r_state;
    logic [IN_NODES*IN_BIT_WIDTH-1:0] r_x;
    logic [INDEX_WIDTH-1:0]          r_idx;
    logic signed [ACC-1:0]           r_acc [RELU_NODES];
    logic [RELU_NODES*W-1:0]         r_w   [IN_NODES];
    logic [RELU_NODES*W-1:0]         r_b;

    logic [IN_BIT_WIDTH-1:0]         w_xSel;
    logic [RELU_NODES*W-1:0]         w_rowSel;
    logic signed [ACC-1:0]           w_prod [RELU_NODES];
    logic [RELU_NODES*OUT_BIT_WIDTH-1:0] w_act;

    // Select the input feature and weight row addressed by the MAC index
    always_comb begin
        w_xSel   = '0;
        w_rowSel = '0;
        for (int i = 0; i < IN_NODES; i++) begin
            if (r_idx == INDEX_WIDTH'(i)) begin
                w_xSel   = r_x[i*IN_BIT_WIDTH +: IN_BIT_WIDTH];
                w_rowSel = r_w[i];
            end
        end
    end

    // Per-node datapath: the product for the MAC step and the bias/ReLU/saturate result for ACT
    for (genvar n = 0; n < RELU_NODES; n++) begin : g_node
        logic [W-1:0]          w_wgt;
        logic [W-1:0]          w_bias;
        logic signed [ACC-1:0] w_xExt;
        logic signed [ACC-1:0] w_wExt;
        logic signed [ACC-1:0] w_bExt;
        logic signed [ACC-1:0] w_sum;
        logic signed [ACC-1:0] w_shift;

        assign w_wgt     = w_rowSel[n*W +: W];
        assign w_bias    = r_b[n*W +: W];
        assign w_xExt    = $signed({{(ACC-IN_BIT_WIDTH){1'b0}}, w_xSel});
        assign w_wExt    = $signed({{(ACC-W){w_wgt[W-1]}}, w_wgt});
        assign w_bExt    = $signed({{(ACC-W){w_bias[W-1]}}, w_bias});
        assign w_prod[n] = w_xExt * w_wExt;
        assign w_sum     = r_acc[n] + w_bExt;
        assign w_shift   = w_sum >>> OUT_SHIFT;
        assign w_act[n*OUT_BIT_WIDTH +: OUT_BIT_WIDTH] =
            w_sum[ACC-1]       ? '0 :
            (w_shift > SAT_MAX) ? {OUT_BIT_WIDTH{1'b1}} :
                                  w_shift[OUT_BIT_WIDTH-1:0];
    end

    // Control FSM with parameter storage, accumulators and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_x            <= '0;
            r_idx          <= '0;
            r_b            <= '0;
            inputsRecieved <= 1'b0;
            outputsReady   <= 1'b0;
            layer1Output   <= '0;
            for (int n = 0; n < RELU_NODES; n++) begin
                r_acc[n] <= '0;
            end
            for (int i = 0; i < IN_NODES; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            inputsRecieved <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    for (int i = 0; i < IN_NODES; i++) begin
                        if (weightWriteEnable && (WriteAddressSelect == INDEX_WIDTH'(i))) begin
                            r_w[i] <= writeIn;
                        end
                    end
                    if (biasWriteEnable) begin
                        r_b <= writeIn;
                    end
                    if (inputsReady) begin
                        r_x            <= layer1Input;
                        inputsRecieved <= 1'b1;
                        r_idx          <= '0;
                        for (int n = 0; n < RELU_NODES; n++) begin
                            r_acc[n] <= '0;
                        end
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int n = 0; n < RELU_NODES; n++) begin
                        r_acc[n] <= r_acc[n] + w_prod[n];
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == INDEX_WIDTH'(IN_NODES - 1)) begin
                        r_state <= S_ACT;
                    end
                end
                S_ACT: begin
                    layer1Output <= w_act;
                    outputsReady <= 1'b1;
                    r_state      <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (outputsRecieved) begin
                        outputsReady <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
